// File: rtl/fft_in_unpack.sv
// Snapshots a 1024-bit SPI frame on a chip-select falling edge, streams it into
// the FFT input RAM most significant word first, then starts the FFT and waits for done.
module fft_in_unpack #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 32,
  parameter int ADDR_W  = $clog2(N_WORDS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic [WORD_W*N_WORDS-1:0] spi_buf,
  input  logic                      fft_done,
  output logic [WORD_W-1:0]         fft_wdata,
  output logic [ADDR_W-1:0]         fft_waddr,
  output logic                      fft_we,
  output logic                      fft_start,
  output logic                      busy,
  output logic                      overrun
);

  localparam int BUF_W = WORD_W * N_WORDS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  cnt_r, cnt_s;
  logic [BUF_W-1:0]   snap_r, snap_s;
  logic               sync1_r, sync2_r, sync3_r;
  logic               done_q_r;
  logic               cs_fall_s;
  logic               done_rise_s;
  logic               we_s;
  logic [ADDR_W-1:0]  waddr_s;
  logic [WORD_W-1:0]  wdata_s;
  logic               start_s;
  logic               busy_s;

  assign cs_fall_s   = ~sync2_r & sync3_r;
  assign done_rise_s = fft_done & ~done_q_r;

  // Next state, counter, snapshot and the output values they imply.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    snap_s  = snap_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) begin
          state_s = LOAD;
          cnt_s   = {ADDR_W{1'b0}};
          snap_s  = spi_buf;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = START;
        end else begin
          cnt_s  = cnt_r + ADDR_W'(1);
          snap_s = {snap_r[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
      end
      START: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (done_rise_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    we_s    = (state_s == LOAD);
    start_s = (state_s == START);
    busy_s  = (state_s != IDLE);
    if (we_s) begin
      waddr_s = cnt_s;
      wdata_s = snap_s[BUF_W-1 -: WORD_W];
    end else begin
      waddr_s = {ADDR_W{1'b0}};
      wdata_s = {WORD_W{1'b0}};
    end
  end

  // State, datapath, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= {ADDR_W{1'b0}};
      snap_r    <= {BUF_W{1'b0}};
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      sync3_r   <= 1'b0;
      done_q_r  <= 1'b0;
      fft_we    <= 1'b0;
      fft_waddr <= {ADDR_W{1'b0}};
      fft_wdata <= {WORD_W{1'b0}};
      fft_start <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      snap_r    <= snap_s;
      sync1_r   <= cs;
      sync2_r   <= sync1_r;
      sync3_r   <= sync2_r;
      done_q_r  <= fft_done;
      fft_we    <= we_s;
      fft_waddr <= waddr_s;
      fft_wdata <= wdata_s;
      fft_start <= start_s;
      busy      <= busy_s;
      if (cs_fall_s && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_fft_in_unpack.sv
// Scoreboard bench: stimulus pushes the expected write/start sequence of each
// accepted frame; a negedge monitor pops and compares everything the DUT emits.
module tb_fft_in_unpack;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic [1023:0] spi_buf;
  logic          fft_done;
  logic [31:0]   fft_wdata;
  logic [4:0]    fft_waddr;
  logic          fft_we;
  logic          fft_start;
  logic          busy;
  logic          overrun;

  fft_in_unpack dut (
    .clk(clk), .reset(reset), .cs(cs), .spi_buf(spi_buf), .fft_done(fft_done),
    .fft_wdata(fft_wdata), .fft_waddr(fft_waddr), .fft_we(fft_we),
    .fft_start(fft_start), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_start;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   start_cnt = 0;
  int   starts_expected = 0;
  bit   model_busy = 1'b0;
  bit   model_overrun = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and start must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (fft_we) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, nothing expected", fft_waddr, fft_wdata);
        end else begin
          me = sb.pop_front();
          chk("entry_is_write", 32'(me.is_start), 32'd0);
          chk("waddr", 32'(fft_waddr), 32'(me.addr));
          chk("wdata", fft_wdata, me.data);
          if (me.addr != 5'd0) chk("write_contiguous", 32'(cyc), 32'(last_cyc + 1));
          last_cyc = cyc;
        end
      end else begin
        chk("idle_wdata", fft_wdata, 32'd0);
        chk("idle_waddr", 32'(fft_waddr), 32'd0);
      end
      if (fft_start) begin
        start_cnt++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_start: got start, nothing expected");
        end else begin
          me = sb.pop_front();
          chk("entry_is_start", 32'(me.is_start), 32'd1);
          chk("start_follows_last_write", 32'(cyc), 32'(last_cyc + 1));
          chk("busy_at_start", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [1023:0] frame);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.is_start = 1'b0;
      e.addr = 5'(k);
      e.data = frame[1023-32*k -: 32];
      sb.push_back(e);
    end
    e.is_start = 1'b1; e.addr = 5'd0; e.data = 32'd0;
    sb.push_back(e);
    starts_expected++;
  endtask

  // Model: a frame is taken only when the block is idle, otherwise it is an overrun.
  task automatic drop();
    cs = 1'b1;
    cycles(3);
    cs = 1'b0;
    if (!model_busy) begin
      push_frame(spi_buf);
      model_busy = 1'b1;
    end else begin
      model_overrun = 1'b1;
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (start_cnt < starts_expected && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(start_cnt), 32'(starts_expected));
  endtask

  task automatic wait_addr(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(fft_we && fft_waddr == 5'(k)) && n < 300);
    chk("reached_addr", 32'(fft_we && fft_waddr == 5'(k)), 32'd1);
  endtask

  task automatic release_done();
    fft_done = 1'b1;
    model_busy = 1'b0;
    @(negedge clk);
    chk("busy_drops_after_done", 32'(busy), 32'd0);
    fft_done = 1'b0;
    cycles(2);
  endtask

  task automatic rand_buf();
    for (int k = 0; k < 32; k++) spi_buf[32*k +: 32] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cs = 1'b1; fft_done = 1'b0; spi_buf = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cs = ~cs;
      @(negedge clk);
      chk("reset_flags", 32'({fft_we, fft_start, busy, overrun}), 32'd0);
      chk("reset_wdata", fft_wdata, 32'd0);
      chk("reset_waddr", 32'(fft_waddr), 32'd0);
    end
    cs = 1'b1;
    reset = 1'b1;
    cycles(4);
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Nominal frame.
    for (int k = 0; k < 32; k++) spi_buf[1023-32*k -: 32] = 32'hA500_0000 + 32'(k);
    drop();
    wait_addr(10);
    chk("busy_in_load", 32'(busy), 32'd1);
    wait_start();
    cycles(2);
    chk("busy_in_wait", 32'(busy), 32'd1);
    release_done();

    // Snapshot isolation: input changes once capture has happened.
    rand_buf();
    drop();
    wait_addr(0);
    cycles(4);
    spi_buf = {1024{1'b1}};
    wait_start();
    release_done();
    chk("no_overrun_yet", 32'(overrun), 32'(model_overrun));

    // Overrun during LOAD and during WAIT.
    rand_buf();
    drop();
    wait_addr(10);
    drop();
    wait_start();
    chk("overrun_load", 32'(overrun), 32'(model_overrun));
    cycles(2);
    drop();
    cycles(6);
    chk("busy_after_wait_drop", 32'(busy), 32'd1);
    chk("overrun_wait", 32'(overrun), 32'(model_overrun));
    release_done();
    rand_buf();
    drop();
    wait_start();
    release_done();
    chk("overrun_sticky", 32'(overrun), 32'(model_overrun));

    // Stale done level does not release WAIT.
    fft_done = 1'b1;
    rand_buf();
    drop();
    wait_start();
    cycles(5);
    chk("stale_done_busy", 32'(busy), 32'd1);
    fft_done = 1'b0;
    cycles(2);
    chk("done_low_busy", 32'(busy), 32'd1);
    release_done();

    // Reset in the middle of LOAD aborts the frame.
    rand_buf();
    drop();
    wait_addr(17);
    #1;
    reset = 1'b0;
    sb.delete();
    starts_expected--;
    model_busy = 1'b0;
    model_overrun = 1'b0;
    @(negedge clk);
    chk("midreset_we", 32'(fft_we), 32'd0);
    chk("midreset_start", 32'(fft_start), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_overrun", 32'(overrun), 32'(model_overrun));
    cycles(2);
    reset = 1'b1;
    cycles(3);
    rand_buf();
    drop();
    wait_start();
    release_done();
    chk("final_overrun", 32'(overrun), 32'(model_overrun));

    cycles(5);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("start_count", 32'(start_cnt), 32'(starts_expected));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
